slot_sequencer: RTL and testbench
=================================

SLOT_SEQUENCER -- requirements
Module: slot_sequencer

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of time slots per frame (2..16).
REQ-002 Parameter TS_W, default 16, width of one slot duration in adc_clk cycles.
REQ-003 Parameter SLOT_W, default 2, equal to clog2(NUM_SLOTS), width of the slot index.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 adc_clk  in  1  clock; all logic on its rising edge.
REQ-006 i_sync  in  1  frame-start request, single-cycle pulse, already synchronous to adc_clk.
REQ-007 i_ts_time  in  NUM_SLOTS*TS_W  packed slot durations, slot k at bits [k*TS_W +: TS_W].
REQ-008 i_slot_en  in  NUM_SLOTS  per-slot enable mask.
REQ-009 i_free_run  in  1  1 = restart the frame automatically after completion, without i_sync.
REQ-010 i_clr_err  in  1  clears o_overrun_cnt.
REQ-011 o_slot  out  SLOT_W  index of the active slot.
REQ-012 o_slot_sync  out  1  single-cycle pulse in the first cycle of each slot.
REQ-013 o_complite  out  1  single-cycle pulse one cycle after the last slot of a frame ends.
REQ-014 o_busy  out  1  high while in RUN state.
REQ-015 o_overrun  out  1  single-cycle pulse when i_sync is rejected.
REQ-016 o_overrun_cnt  out  8  saturating count of rejected syncs.

Function
REQ-017 States: IDLE and RUN; the FSM has exactly these two states.
REQ-018 IDLE, on start (i_sync=1, or i_free_run=1 in the cycle o_complite is high), latches i_ts_time and i_slot_en into shadow registers.
REQ-019 Frame config is taken only from the shadow registers; input changes mid-frame take effect next frame.
REQ-020 A slot is active when its shadow enable is 1 and its shadow duration is nonzero; inactive slots are skipped with no cycle cost.
REQ-021 Start with at least one active slot: next cycle RUN, o_slot = lowest active index, o_slot_sync=1, slot counter=0.
REQ-022 Start with no active slot: next cycle o_complite=1, state stays IDLE, no o_slot_sync.
REQ-023 RUN: the slot counter (TS_W bits) increments each cycle; at counter == duration-1 the sequencer advances.
REQ-024 Advance moves to the next higher active index: next cycle o_slot updates, o_slot_sync=1, counter=0.
REQ-025 When no higher active slot exists: next cycle IDLE, o_complite=1, o_slot holds its last value.
REQ-026 Each slot therefore lasts exactly duration cycles; frame length = sum of active durations, plus 1 cycle for o_complite.
REQ-027 i_sync while RUN is ignored, pulses o_overrun next cycle, and increments o_overrun_cnt, saturating at 255.
REQ-028 i_sync in the o_complite cycle (state IDLE) is accepted as a new start, not an overrun.
REQ-029 i_free_run=1: start condition is the o_complite cycle itself, giving back-to-back frames with a 1-cycle gap; i_sync in that cycle is merged, not an overrun.
REQ-030 i_clr_err and an overrun in the same cycle: the counter is set to 1.
REQ-031 i_free_run dropped mid-frame: the current frame completes and no restart occurs.

Reset
REQ-032 Reset values: state IDLE; o_slot=0; o_slot_sync=0; o_complite=0; o_busy=0; o_overrun=0; o_overrun_cnt=0; slot counter=0; shadow registers=0.
REQ-033 Reset asserted mid-frame aborts immediately with no o_complite; after release the block waits in IDLE for a start.

Structure
REQ-034 Shared package dscope_pkg holds the FSM state encoding (IDLE=0, RUN=1) and the default NUM_SLOTS/TS_W/SLOT_W constants.
REQ-035 Sub-module slot_next_sel: combinational next-active-index finder (inputs: active mask and current index; outputs: next index and found flag), used for both the first-slot and the advance searches.
REQ-036 All outputs are registered; no combinational path from inputs to outputs.

Verification
REQ-037 Durations {4,3,2,5}, all enabled, i_sync at cycle 0 -> o_slot_sync at cycles 1,5,8,10 with slots 0..3; o_complite at cycle 15.
REQ-038 Enable mask 4'b1010, durations {4,3,0,5} -> slot 1 at cycle 1, slot 3 at cycle 4, o_complite at cycle 9; slots 0 and 2 never appear.
REQ-039 Mask 0 plus i_sync -> o_complite at next cycle, o_busy stays 0, no o_slot_sync.
REQ-040 Overrun: i_sync at cycles 0,3,6 with durations {4,3,2,5} -> o_overrun at cycles 4 and 7, o_overrun_cnt=2, frame timing unchanged; 300 rejected syncs -> count 255; i_clr_err -> 0.
REQ-041 i_free_run=1, durations {2,2,2,2} -> o_complite every 9 cycles, each immediately followed by slot 0 o_slot_sync; durations changed mid-frame take effect only in the next frame.
REQ-042 rst_n low at cycle 6 of a frame -> all outputs 0 and no o_complite; i_sync after release -> normal frame.

Source files
------------

// File: rtl/dscope_pkg.sv
// Shared definitions for the slot sequencer: FSM encoding and default sizing.
package dscope_pkg;

  localparam int NUM_SLOTS_DEF = 4;
  localparam int TS_W_DEF      = 16;
  localparam int SLOT_W_DEF    = 2;

  localparam logic [7:0] OVR_CNT_MAX = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/slot_next_sel.sv
// Finds the next active slot index. With first=1 the search starts at slot 0
// inclusive, otherwise it looks strictly above cur_idx.
module slot_next_sel #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [SLOT_W-1:0]    cur_idx,
  input  logic                 first,
  output logic [SLOT_W-1:0]    next_idx,
  output logic                 found
);

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (mask[k] && (first || (k > int'(cur_idx)))) begin
        next_idx = SLOT_W'(k);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slot_sequencer.sv
// Frame slot sequencer: walks the enabled, nonzero-duration slots of a frame,
// one slot after another, using a config snapshot taken at frame start.
//
// state   | meaning
// IDLE    | waiting for i_sync, or for the free-run restart in the complete cycle
// RUN     | a slot is active; counter runs up to its duration-1
module slot_sequencer
  import dscope_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int TS_W      = TS_W_DEF,
  parameter int SLOT_W    = SLOT_W_DEF
) (
  input  logic                      rst_n,
  input  logic                      adc_clk,
  input  logic                      i_sync,
  input  logic [NUM_SLOTS*TS_W-1:0] i_ts_time,
  input  logic [NUM_SLOTS-1:0]      i_slot_en,
  input  logic                      i_free_run,
  input  logic                      i_clr_err,
  output logic [SLOT_W-1:0]         o_slot,
  output logic                      o_slot_sync,
  output logic                      o_complite,
  output logic                      o_busy,
  output logic                      o_overrun,
  output logic [7:0]                o_overrun_cnt
);

  state_t                    state, state_nx;
  logic [NUM_SLOTS*TS_W-1:0] sh_ts, sh_ts_nx;
  logic [NUM_SLOTS-1:0]      sh_en, sh_en_nx;
  logic [TS_W-1:0]           cnt, cnt_nx;
  logic [SLOT_W-1:0]         slot_nx;
  logic                      ss_nx, cpl_nx, ovr_nx;
  logic [7:0]                ocnt_nx;

  logic [NUM_SLOTS-1:0]      act_in, act_sh;
  logic [SLOT_W-1:0]         first_idx, adv_idx;
  logic                      first_found, adv_found;
  logic [TS_W-1:0]           cur_dur;
  logic                      start;

  // Active masks: the live inputs for the start decision, the snapshot for advancing.
  always_comb begin
    act_in = '0;
    act_sh = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      act_in[k] = i_slot_en[k] && (i_ts_time[k*TS_W +: TS_W] != '0);
      act_sh[k] = sh_en[k] && (sh_ts[k*TS_W +: TS_W] != '0);
    end
  end

  assign cur_dur = sh_ts[int'(o_slot)*TS_W +: TS_W];
  assign start   = (state == ST_IDLE) && (i_sync || (i_free_run && o_complite));
  assign o_busy  = (state == ST_RUN);

  slot_next_sel #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_first_sel (
    .mask     (act_in),
    .cur_idx  ('0),
    .first    (1'b1),
    .next_idx (first_idx),
    .found    (first_found)
  );

  slot_next_sel #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_adv_sel (
    .mask     (act_sh),
    .cur_idx  (o_slot),
    .first    (1'b0),
    .next_idx (adv_idx),
    .found    (adv_found)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nx = state;
    sh_ts_nx = sh_ts;
    sh_en_nx = sh_en;
    cnt_nx   = cnt;
    slot_nx  = o_slot;
    ss_nx    = 1'b0;
    cpl_nx   = 1'b0;
    ovr_nx   = 1'b0;
    ocnt_nx  = o_overrun_cnt;

    case (state)
      ST_IDLE: begin
        if (start) begin
          sh_ts_nx = i_ts_time;
          sh_en_nx = i_slot_en;
          cnt_nx   = '0;
          if (first_found) begin
            state_nx = ST_RUN;
            slot_nx  = first_idx;
            ss_nx    = 1'b1;
          end else begin
            cpl_nx = 1'b1;
          end
        end
      end
      ST_RUN: begin
        ovr_nx = i_sync;
        if (cnt == cur_dur - TS_W'(1)) begin
          cnt_nx = '0;
          if (adv_found) begin
            slot_nx = adv_idx;
            ss_nx   = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            cpl_nx   = 1'b1;
          end
        end else begin
          cnt_nx = cnt + TS_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // A clear coinciding with an overrun still records that overrun.
    if (ovr_nx) begin
      if (i_clr_err)                         ocnt_nx = 8'd1;
      else if (o_overrun_cnt != OVR_CNT_MAX) ocnt_nx = o_overrun_cnt + 8'd1;
    end else if (i_clr_err) begin
      ocnt_nx = 8'd0;
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sh_ts         <= '0;
      sh_en         <= '0;
      cnt           <= '0;
      o_slot        <= '0;
      o_slot_sync   <= 1'b0;
      o_complite    <= 1'b0;
      o_overrun     <= 1'b0;
      o_overrun_cnt <= 8'd0;
    end else begin
      state         <= state_nx;
      sh_ts         <= sh_ts_nx;
      sh_en         <= sh_en_nx;
      cnt           <= cnt_nx;
      o_slot        <= slot_nx;
      o_slot_sync   <= ss_nx;
      o_complite    <= cpl_nx;
      o_overrun     <= ovr_nx;
      o_overrun_cnt <= ocnt_nx;
    end
  end

endmodule

// File: tb/tb_slot_sequencer.sv
// Bench for slot_sequencer: per-cycle comparison against a frame-schedule model.
module tb_slot_sequencer;

  localparam int NS   = 4;
  localparam int TW   = 16;
  localparam int SW   = 2;
  localparam int MAXC = 2048;

  logic              adc_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_sync = 1'b0;
  logic [NS*TW-1:0]  i_ts_time = '0;
  logic [NS-1:0]     i_slot_en = '0;
  logic              i_free_run = 1'b0;
  logic              i_clr_err = 1'b0;
  logic [SW-1:0]     o_slot;
  logic              o_slot_sync, o_complite, o_busy, o_overrun;
  logic [7:0]        o_overrun_cnt;

  // stimulus per cycle
  logic              sync_a [MAXC];
  logic              fr_a   [MAXC];
  logic              clr_a  [MAXC];
  logic [NS*TW-1:0]  ts_a   [MAXC];
  logic [NS-1:0]     en_a   [MAXC];
  // expected outputs per cycle
  int                exp_slot [MAXC];
  logic              exp_ss   [MAXC];
  logic              exp_cpl  [MAXC];
  logic              exp_busy [MAXC];
  logic              exp_ovr  [MAXC];
  int                exp_cnt  [MAXC];

  int checks   = 0;
  int failures = 0;

  always #5 adc_clk = ~adc_clk;

  slot_sequencer #(.NUM_SLOTS(NS), .TS_W(TW), .SLOT_W(SW)) dut (
    .rst_n         (rst_n),
    .adc_clk       (adc_clk),
    .i_sync        (i_sync),
    .i_ts_time     (i_ts_time),
    .i_slot_en     (i_slot_en),
    .i_free_run    (i_free_run),
    .i_clr_err     (i_clr_err),
    .o_slot        (o_slot),
    .o_slot_sync   (o_slot_sync),
    .o_complite    (o_complite),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun),
    .o_overrun_cnt (o_overrun_cnt)
  );

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [NS*TW-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {TW'(d3), TW'(d2), TW'(d1), TW'(d0)};
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      sync_a[c] = 1'b0; fr_a[c] = 1'b0; clr_a[c] = 1'b0;
      ts_a[c] = '0; en_a[c] = '0;
    end
  endtask

  task automatic set_cfg(input int from, input int to, input logic [NS*TW-1:0] ts, input logic [NS-1:0] en);
    for (int c = from; c < to; c++) begin
      ts_a[c] = ts; en_a[c] = en;
    end
  endtask

  // Frame schedule: a start at cycle c lays out its active slots back to back
  // from c+1, with the complete pulse right after the last one.
  task automatic build_model(input int n);
    int busy_until, pos, d, nxt;
    for (int c = 0; c < MAXC; c++) begin
      exp_slot[c] = 0; exp_ss[c] = 1'b0; exp_cpl[c] = 1'b0;
      exp_busy[c] = 1'b0; exp_ovr[c] = 1'b0; exp_cnt[c] = 0;
    end
    busy_until = -1;
    for (int c = 0; c < n; c++) begin
      if (c > busy_until) begin
        if (sync_a[c] || (fr_a[c] && exp_cpl[c])) begin
          pos = c + 1;
          for (int k = 0; k < NS; k++) begin
            d = int'(ts_a[c][k*TW +: TW]);
            if (en_a[c][k] && d != 0) begin
              exp_ss[pos] = 1'b1;
              for (int j = pos; j < MAXC; j++) exp_slot[j] = k;
              for (int j = pos; j < pos + d && j < MAXC; j++) exp_busy[j] = 1'b1;
              pos += d;
            end
          end
          exp_cpl[pos] = 1'b1;
          busy_until = pos - 1;
        end
      end else if (sync_a[c]) begin
        exp_ovr[c+1] = 1'b1;
      end
    end
    for (int c = 0; c < n; c++) begin
      nxt = exp_cnt[c];
      if (exp_ovr[c+1]) nxt = clr_a[c] ? 1 : ((nxt < 255) ? nxt + 1 : 255);
      else if (clr_a[c]) nxt = 0;
      exp_cnt[c+1] = nxt;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_sync = 1'b0; i_free_run = 1'b0; i_clr_err = 1'b0;
    i_ts_time = '0; i_slot_en = '0;
    repeat (2) @(posedge adc_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_cycle(input int c);
    chk("slot",      c, 32'(o_slot),        32'(exp_slot[c]));
    chk("slot_sync", c, 32'(o_slot_sync),   32'(exp_ss[c]));
    chk("complite",  c, 32'(o_complite),    32'(exp_cpl[c]));
    chk("busy",      c, 32'(o_busy),        32'(exp_busy[c]));
    chk("overrun",   c, 32'(o_overrun),     32'(exp_ovr[c]));
    chk("ovr_cnt",   c, 32'(o_overrun_cnt), 32'(exp_cnt[c]));
  endtask

  task automatic drive_cycles(input int from, input int to);
    for (int c = from; c < to; c++) begin
      check_cycle(c);
      i_sync = sync_a[c]; i_free_run = fr_a[c]; i_clr_err = clr_a[c];
      i_ts_time = ts_a[c]; i_slot_en = en_a[c];
      @(posedge adc_clk);
      #1;
    end
  endtask

  task automatic run(input int n);
    do_reset();
    build_model(n);
    drive_cycles(0, n);
  endtask

  initial begin
    logic [NS*TW-1:0] rts;
    logic [NS-1:0]    ren;
    logic             rfr;

    // all slots enabled, durations 4,3,2,5
    clear_stim();
    set_cfg(0, 30, pack(4, 3, 2, 5), 4'hF);
    sync_a[0] = 1'b1;
    run(20);

    // sparse mask with a zero-length enabled slot
    clear_stim();
    set_cfg(0, 20, pack(4, 3, 0, 5), 4'b1010);
    sync_a[0] = 1'b1;
    run(14);

    // empty mask: immediate complete
    clear_stim();
    set_cfg(0, 10, pack(4, 3, 2, 5), 4'b0000);
    sync_a[0] = 1'b1;
    run(5);

    // overruns during a frame, then sync in the complete cycle is a new start
    clear_stim();
    set_cfg(0, 40, pack(4, 3, 2, 5), 4'hF);
    sync_a[0] = 1'b1; sync_a[3] = 1'b1; sync_a[6] = 1'b1; sync_a[15] = 1'b1;
    run(34);

    // clear coinciding with an overrun
    clear_stim();
    set_cfg(0, 30, pack(4, 3, 2, 5), 4'hF);
    sync_a[0] = 1'b1; sync_a[3] = 1'b1; sync_a[6] = 1'b1; clr_a[6] = 1'b1;
    run(18);

    // counter saturation and clear
    clear_stim();
    set_cfg(0, 440, pack(100, 100, 100, 100), 4'hF);
    for (int c = 0; c <= 410; c++) sync_a[c] = 1'b1;
    clr_a[420] = 1'b1;
    run(425);

    // free run, config change mid-frame, free run dropped mid-frame
    clear_stim();
    set_cfg(0, 14, pack(2, 2, 2, 2), 4'hF);
    set_cfg(14, 80, pack(3, 3, 3, 3), 4'hF);
    for (int c = 0; c < 40; c++) fr_a[c] = 1'b1;
    sync_a[0] = 1'b1; sync_a[9] = 1'b1;
    run(60);

    // reset mid-frame at cycle 6
    clear_stim();
    set_cfg(0, 20, pack(4, 3, 2, 5), 4'hF);
    sync_a[0] = 1'b1;
    do_reset();
    build_model(20);
    drive_cycles(0, 6);
    rst_n = 1'b0;
    i_sync = 1'b0;
    #1;
    chk("rst_slot", 6, 32'(o_slot), 32'd0);
    chk("rst_ss",   6, 32'(o_slot_sync), 32'd0);
    chk("rst_busy", 6, 32'(o_busy), 32'd0);
    chk("rst_cnt",  6, 32'(o_overrun_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge adc_clk); #1;
      chk("rst_cpl",  7 + i, 32'(o_complite), 32'd0);
      chk("rst_busy", 7 + i, 32'(o_busy), 32'd0);
    end
    clear_stim();
    set_cfg(0, 30, pack(4, 3, 2, 5), 4'hF);
    sync_a[0] = 1'b1;
    run(20);

    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      rts = '0; ren = '0; rfr = 1'b0;
      for (int c = 0; c < 250; c++) begin
        if (c == 0 || $urandom_range(0, 19) == 0) begin
          rts = pack(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
          ren = NS'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 49) == 0) rfr = ~rfr;
        ts_a[c] = rts; en_a[c] = ren; fr_a[c] = rfr;
        sync_a[c] = ($urandom_range(0, 7) == 0);
        clr_a[c] = ($urandom_range(0, 39) == 0);
      end
      run(250);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
